// File: rtl/volley_pkg.sv
// Shared types and defaults for the volleyball match controller.
package volley_pkg;

   localparam int SETS_TO_WIN_DEF = 3;
   localparam int PNT_W_DEF       = 5;
   localparam int SET_W_DEF       = 3;

   typedef enum logic [1:0] {
      CLEAR   = 2'd0,
      PLAY    = 2'd1,
      SET_END = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_T1   = 2'b01;
   localparam logic [1:0] WIN_T2   = 2'b10;

endpackage

// File: rtl/volley_set_controller_rise_detect.sv
// Registered rising-edge detector with synchronous reset.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b0;
      else     prev <= d;
   end

   assign rise = d & ~prev;

endmodule

// File: rtl/volley_set_controller.sv
// Match-level set tally and sequencing for paired point counters.
// Optional SET_HISTORY_EN keeps the final score of every set.
module volley_set_controller
   import volley_pkg::*;
#(
   parameter int SETS_TO_WIN = SETS_TO_WIN_DEF,
   parameter int PNT_W       = PNT_W_DEF,
   parameter int SET_W       = SET_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RCOpnt1,
   input  logic               RCOpnt2,
   input  logic [PNT_W-1:0]   pnt1,
   input  logic [PNT_W-1:0]   pnt2,
   input  logic               next_set,
`ifdef SET_HISTORY_EN
   input  logic [SET_W-1:0]   hist_idx,
   output logic [2*PNT_W-1:0] hist_score,
`endif
   output logic [SET_W-1:0]   set1,
   output logic [SET_W-1:0]   set2,
   output logic [SET_W-1:0]   set_num,
   output logic               rstpnt,
   output logic               mode25_15,
   output logic               set_end,
   output logic               match_over,
   output logic [1:0]         winner
);

   localparam int NSETS = 2*SETS_TO_WIN-1;
   localparam logic [SET_W-1:0] TARGET   = SET_W'(SETS_TO_WIN);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NSETS);

   state_t state, state_n;
   logic rise1, rise2, accept;
   logic [SET_W-1:0] set1_n, set2_n, num_n;
   logic [1:0] win_n;

   rise_detect u_rd1 (
      .clk  (clk),
      .rst  (rst),
      .d    (RCOpnt1),
      .rise (rise1)
   );

   rise_detect u_rd2 (
      .clk  (clk),
      .rst  (rst),
      .d    (RCOpnt2),
      .rise (rise2)
   );

   assign accept = (state == PLAY) && (rise1 ^ rise2);

   always_comb begin
      state_n = state;
      set1_n  = set1;
      set2_n  = set2;
      num_n   = set_num;
      win_n   = winner;
      unique case (state)
         CLEAR: state_n = PLAY;
         PLAY: begin
            unique case (1'b1)
               (rise1 & ~rise2): begin
                  if (set1 != TARGET) set1_n = set1 + 1'b1;
                  win_n   = WIN_T1;
                  state_n = (set1_n == TARGET) ? DONE : SET_END;
               end
               (rise2 & ~rise1): begin
                  if (set2 != TARGET) set2_n = set2 + 1'b1;
                  win_n   = WIN_T2;
                  state_n = (set2_n == TARGET) ? DONE : SET_END;
               end
               default: ;
            endcase
         end
         SET_END: begin
            if (next_set) begin
               if (set_num != LAST_SET) num_n = set_num + 1'b1;
               state_n = CLEAR;
            end
         end
         DONE: ;
         default: state_n = CLEAR;
      endcase
   end

   // Outputs are registered from next-state values so they align with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         set1       <= '0;
         set2       <= '0;
         set_num    <= SET_W'(1);
         winner     <= WIN_NONE;
         rstpnt     <= 1'b1;
         set_end    <= 1'b0;
         match_over <= 1'b0;
         mode25_15  <= 1'b0;
      end else begin
         state      <= state_n;
         set1       <= set1_n;
         set2       <= set2_n;
         set_num    <= num_n;
         winner     <= win_n;
         rstpnt     <= (state_n == CLEAR);
         set_end    <= (state_n == SET_END);
         match_over <= (state_n == DONE);
         mode25_15  <= (num_n == LAST_SET);
      end
   end

`ifdef SET_HISTORY_EN
   logic [2*PNT_W-1:0] hist [NSETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSETS; i++) hist[i] <= '0;
      end else if (accept) begin
         hist[set_num - 1'b1] <= {pnt1, pnt2};
      end
   end

   assign hist_score = (hist_idx < LAST_SET) ? hist[hist_idx] : '0;
`else
   logic unused_pnt;
   assign unused_pnt = ^{pnt1, pnt2, accept};
`endif

endmodule

// File: tb/tb_volley_set_controller.sv
// Directed self-checking bench for volley_set_controller.
module tb_volley_set_controller;
   import volley_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       RCOpnt1, RCOpnt2, next_set;
   logic [4:0] pnt1, pnt2;
   logic [2:0] set1, set2, set_num;
   logic       rstpnt, mode25_15, set_end, match_over;
   logic [1:0] winner;
`ifdef SET_HISTORY_EN
   logic [2:0] hist_idx;
   logic [9:0] hist_score;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   volley_set_controller dut (
      .clk        (clk),
      .rst        (rst),
      .RCOpnt1    (RCOpnt1),
      .RCOpnt2    (RCOpnt2),
      .pnt1       (pnt1),
      .pnt2       (pnt2),
      .next_set   (next_set),
`ifdef SET_HISTORY_EN
      .hist_idx   (hist_idx),
      .hist_score (hist_score),
`endif
      .set1       (set1),
      .set2       (set2),
      .set_num    (set_num),
      .rstpnt     (rstpnt),
      .mode25_15  (mode25_15),
      .set_end    (set_end),
      .match_over (match_over),
      .winner     (winner)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      RCOpnt1  = 1'b0;
      RCOpnt2  = 1'b0;
      next_set = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Win one set for team t, then confirm and return to PLAY.
   task automatic win_set(input int t);
      if (t == 1) RCOpnt1 = 1'b1;
      else        RCOpnt2 = 1'b1;
      tick();
      RCOpnt1 = 1'b0;
      RCOpnt2 = 1'b0;
      tick();
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({rstpnt, set1, set2, set_num, mode25_15, set_end, match_over, winner}
          !== {1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00})
         $display("FAIL reset_state got rp=%b s1=%0d s2=%0d n=%0d m=%b se=%b mo=%b w=%b want 1 0 0 1 0 0 0 00",
                  rstpnt, set1, set2, set_num, mode25_15, set_end, match_over, winner);
      else passed++;
      tick();
      total++;
      if (rstpnt !== 1'b0)
         $display("FAIL rstpnt_one_cycle got %b want 0", rstpnt);
      else passed++;
   endtask

   task automatic test_hold();
      RCOpnt1 = 1'b1;
      tick();
      total++;
      if ({set1, set2, set_end} !== {3'd1, 3'd0, 1'b1})
         $display("FAIL hold_first got s1=%0d s2=%0d se=%b want 1 0 1", set1, set2, set_end);
      else passed++;
      repeat (9) tick();
      total++;
      if ({set1, set_end} !== {3'd1, 1'b1})
         $display("FAIL hold_no_recount got s1=%0d se=%b want 1 1", set1, set_end);
      else passed++;
      RCOpnt1  = 1'b0;
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      total++;
      if ({set_num, rstpnt, set_end} !== {3'd2, 1'b1, 1'b0})
         $display("FAIL next_set got n=%0d rp=%b se=%b want 2 1 0", set_num, rstpnt, set_end);
      else passed++;
      tick();
      total++;
      if (rstpnt !== 1'b0)
         $display("FAIL next_set_rp_end got %b want 0", rstpnt);
      else passed++;
   endtask

   task automatic test_match();
      do_reset();
      tick();
      win_set(1);
      win_set(2);
      win_set(1);
      total++;
      if ({set_num, mode25_15} !== {3'd4, 1'b0})
         $display("FAIL set4_mode got n=%0d m=%b want 4 0", set_num, mode25_15);
      else passed++;
      win_set(2);
      total++;
      if ({set1, set2, set_num, mode25_15} !== {3'd2, 3'd2, 3'd5, 1'b1})
         $display("FAIL set5_mode got s1=%0d s2=%0d n=%0d m=%b want 2 2 5 1",
                  set1, set2, set_num, mode25_15);
      else passed++;
      RCOpnt2 = 1'b1;
      tick();
      RCOpnt2 = 1'b0;
      total++;
      if ({set2, match_over, winner, set_end} !== {3'd3, 1'b1, WIN_T2, 1'b0})
         $display("FAIL match_win got s2=%0d mo=%b w=%b se=%b want 3 1 10 0",
                  set2, match_over, winner, set_end);
      else passed++;
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      RCOpnt1  = 1'b1;
      tick();
      RCOpnt1 = 1'b0;
      tick();
      total++;
      if ({set1, set2, set_num, match_over, winner, rstpnt}
          !== {3'd2, 3'd3, 3'd5, 1'b1, WIN_T2, 1'b0})
         $display("FAIL done_hold got s1=%0d s2=%0d n=%0d mo=%b w=%b rp=%b want 2 3 5 1 10 0",
                  set1, set2, set_num, match_over, winner, rstpnt);
      else passed++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      tick();
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      total++;
      if ({set_num, rstpnt} !== {3'd1, 1'b0})
         $display("FAIL next_set_in_play got n=%0d rp=%b want 1 0", set_num, rstpnt);
      else passed++;
      RCOpnt1 = 1'b1;
      RCOpnt2 = 1'b1;
      tick();
      total++;
      if ({set1, set2, set_end, match_over} !== {3'd0, 3'd0, 1'b0, 1'b0})
         $display("FAIL both_rise got s1=%0d s2=%0d se=%b want 0 0 0", set1, set2, set_end);
      else passed++;
      RCOpnt1 = 1'b0;
      RCOpnt2 = 1'b0;
      tick();
      RCOpnt1 = 1'b1;
      tick();
      RCOpnt1 = 1'b0;
      total++;
      if ({set1, set_end} !== {3'd1, 1'b1})
         $display("FAIL still_play got s1=%0d se=%b want 1 1", set1, set_end);
      else passed++;
   endtask

   task automatic test_reset_mid();
      tick();
      next_set = 1'b1;
      tick();
      next_set = 1'b0;
      tick();
      RCOpnt1 = 1'b1;
      tick();
      RCOpnt1 = 1'b0;
      total++;
      if ({set1, set_end, set_num} !== {3'd2, 1'b1, 3'd2})
         $display("FAIL pre_reset got s1=%0d se=%b n=%0d want 2 1 2", set1, set_end, set_num);
      else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({set1, set2, set_num, rstpnt, set_end} !== {3'd0, 3'd0, 3'd1, 1'b1, 1'b0})
         $display("FAIL reset_mid got s1=%0d s2=%0d n=%0d rp=%b se=%b want 0 0 1 1 0",
                  set1, set2, set_num, rstpnt, set_end);
      else passed++;
      tick();
      total++;
      if (rstpnt !== 1'b0)
         $display("FAIL reset_mid_rp got %b want 0", rstpnt);
      else passed++;
   endtask

`ifdef SET_HISTORY_EN
   task automatic test_history();
      do_reset();
      tick();
      pnt1 = 5'd25;
      pnt2 = 5'd23;
      RCOpnt1 = 1'b1;
      tick();
      RCOpnt1 = 1'b0;
      pnt1 = 5'd3;
      pnt2 = 5'd4;
      hist_idx = 3'd0;
      #1;
      total++;
      if (hist_score !== {5'd25, 5'd23})
         $display("FAIL hist_idx0 got %h want %h", hist_score, {5'd25, 5'd23});
      else passed++;
      hist_idx = 3'd1;
      #1;
      total++;
      if (hist_score !== 10'd0)
         $display("FAIL hist_idx1 got %h want 0", hist_score);
      else passed++;
   endtask
`endif

   initial begin
      pnt1 = 5'd0;
      pnt2 = 5'd0;
`ifdef SET_HISTORY_EN
      hist_idx = 3'd0;
`endif
      test_reset();
      test_hold();
      test_match();
      test_simultaneous();
      test_reset_mid();
`ifdef SET_HISTORY_EN
      test_history();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
